// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared game states, peg widths and result legality check.
package mastermind_pkg;

    typedef enum logic [1:0] {IDLE, PLAYING, WON, LOST} state_e;

    localparam int PEG_W    = 3;
    localparam int NUM_PEGS = 4;
    localparam int CODE_W   = 12;
    localparam logic [PEG_W-1:0] WIN_RED = 3'd4;

    // Sum is widened by one bit so 7+7 cannot wrap into a legal-looking value.
    function automatic logic result_legal(input logic [PEG_W-1:0] r, input logic [PEG_W-1:0] w);
        return (r <= WIN_RED) && (w <= WIN_RED) && (({1'b0, r} + {1'b0, w}) <= 4'(NUM_PEGS));
    endfunction

endpackage

// File: rtl/mastermind_referee_blink_divider.sv
// blink_divider: toggles blink every BLINK_DIV cycles while enabled, holds 1 otherwise.
module blink_divider #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic blink_o
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        cnt_d   = enable_i ? ((cnt_q == CW'(BLINK_DIV - 1)) ? '0 : cnt_q + 1'b1) : '0;
        blink_d = enable_i ? ((cnt_q == CW'(BLINK_DIV - 1)) ? ~blink_q : blink_q) : 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    // The register still holds the last phase for one cycle after leaving a terminal state.
    assign blink_o = enable_i ? blink_q : 1'b1;

endmodule

// File: rtl/mastermind_referee.sv
// mastermind_referee: scores guesses against a limit, keeps result history, drives end-of-game display controls.
module mastermind_referee
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES = 8,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             new_game_i,
    input  logic             result_valid_i,
    input  logic [PEG_W-1:0] red_i,
    input  logic [PEG_W-1:0] white_i,
    output logic             accept_guess_o,
    output logic             won_o,
    output logic             lost_o,
    output logic [3:0]       guess_count_o,
    output logic [PEG_W-1:0] disp_red_o,
    output logic [PEG_W-1:0] disp_white_o,
    output logic             blink_o,
    output logic             reveal_code_o,
    output logic             protocol_err_o,
    input  logic [2:0]       hist_idx_i,
    output logic [PEG_W-1:0] hist_red_o,
    output logic [PEG_W-1:0] hist_white_o,
    output logic             hist_valid_o
);

    state_e                        state_q, state_d;
    logic [3:0]                    count_q, count_d;
    logic [7:0][2*PEG_W-1:0]       hist_q, hist_d;
    logic                          perr_q, perr_d;
    logic [PEG_W-1:0]              disp_red_q, disp_red_d;
    logic [PEG_W-1:0]              disp_white_q, disp_white_d;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hist_d       = hist_q;
        perr_d       = perr_q;
        disp_red_d   = disp_red_q;
        disp_white_d = disp_white_q;
        if (new_game_i) begin
            state_d      = PLAYING;
            count_d      = '0;
            perr_d       = 1'b0;
            disp_red_d   = '0;
            disp_white_d = '0;
        end else if (result_valid_i && state_q == PLAYING) begin
            if (!result_legal(red_i, white_i)) begin
                perr_d = 1'b1;
            end else begin
                hist_d[count_q[2:0]] = {red_i, white_i};
                count_d              = count_q + 4'd1;
                disp_red_d           = red_i;
                disp_white_d         = white_i;
                // A win on the final guess still counts as a win.
                state_d = (red_i == WIN_RED) ? WON :
                          (count_d == 4'(MAX_GUESSES)) ? LOST : PLAYING;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            hist_q       <= '0;
            perr_q       <= 1'b0;
            disp_red_q   <= '0;
            disp_white_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hist_q       <= hist_d;
            perr_q       <= perr_d;
            disp_red_q   <= disp_red_d;
            disp_white_q <= disp_white_d;
        end
    end

    blink_divider #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (state_q == WON || state_q == LOST),
        .blink_o  (blink_o)
    );

    assign accept_guess_o = state_q == PLAYING;
    assign won_o          = state_q == WON;
    assign lost_o         = state_q == LOST;
    assign reveal_code_o  = state_q == LOST;
    assign guess_count_o  = count_q;
    assign protocol_err_o = perr_q;
    assign disp_red_o     = disp_red_q;
    assign disp_white_o   = disp_white_q;
    assign hist_red_o     = hist_q[hist_idx_i][2*PEG_W-1 -: PEG_W];
    assign hist_white_o   = hist_q[hist_idx_i][PEG_W-1:0];
    assign hist_valid_o   = {1'b0, hist_idx_i} < count_q;

endmodule
